screen_ram_arbiter: RTL and testbench

SCREEN_RAM_ARBITER -- requirements
Module: screen_ram_arbiter

---
 rtl/hack_screen_pkg.sv | 15 +
 rtl/screen_ram_arbiter_if.sv | 41 ++++
 rtl/screen_word_cache.sv | 66 ++++++
 rtl/screen_ram_arbiter.sv | 114 +++++++++++
 tb/tb_screen_ram_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hack_screen_pkg.sv
// Shared types and sizes for the Hack screen RAM arbiter.
// Holds the screen address/word widths, their typedefs and the width of the
// CPU wait counter.
package hack_screen_pkg;

  localparam int SCREEN_AW = 13;
  localparam int SCREEN_DW = 16;

  // Wide enough for any wait limit in 1..255
  localparam int WAIT_W = 8;

  typedef logic [SCREEN_AW-1:0] screen_addr_t;
  typedef logic [SCREEN_DW-1:0] screen_word_t;

endpackage

// File: rtl/screen_ram_arbiter_if.sv
// Bus bundle between the screen RAM arbiter and its surroundings.
// Groups three sides:
//   VGA : vga_en, vga_addr -> vga_rdata, vga_stale
//   CPU : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_ready, cpu_rvalid, cpu_rdata
//   RAM : ram_addr, ram_we, ram_wdata -> ram_rdata (one-cycle read latency)
// Modport master is the environment (VGA scanner, CPU, RAM).
// Modport slave is the arbiter itself.
interface screen_ram_arbiter_if;
  import hack_screen_pkg::*;

  logic         vga_en;
  screen_addr_t vga_addr;
  screen_word_t vga_rdata;
  logic         vga_stale;

  logic         cpu_req;
  logic         cpu_we;
  screen_addr_t cpu_addr;
  screen_word_t cpu_wdata;
  logic         cpu_ready;
  logic         cpu_rvalid;
  screen_word_t cpu_rdata;

  screen_addr_t ram_addr;
  logic         ram_we;
  screen_word_t ram_wdata;
  screen_word_t ram_rdata;

  modport master (
    output vga_en, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vga_rdata, vga_stale, cpu_ready, cpu_rvalid, cpu_rdata,
           ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  vga_en, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vga_rdata, vga_stale, cpu_ready, cpu_rvalid, cpu_rdata,
           ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/screen_word_cache.sv
// One-word cache in front of the screen RAM for the VGA side.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   lookup_addr  : VGA address compared against the stored tag
//   hit          : stored tag is valid and equals lookup_addr
//   fill_start   : a VGA miss owns the RAM this cycle; retarget to lookup_addr
//   ram_rdata    : RAM read data, lands one cycle after fill_start
//   wr_en        : granted CPU write this cycle
//   wr_addr      : CPU write address
//   wr_data      : CPU write data
//   rdata        : word for the address looked up one cycle earlier
module screen_word_cache
  import hack_screen_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  screen_addr_t lookup_addr,
  output logic         hit,
  input  logic         fill_start,
  input  screen_word_t ram_rdata,
  input  logic         wr_en,
  input  screen_addr_t wr_addr,
  input  screen_word_t wr_data,
  output screen_word_t rdata
);

  screen_addr_t tag;
  logic         tag_valid;
  screen_word_t cache_data;
  logic         fill;
  logic         write_through;

  assign hit           = tag_valid && (lookup_addr == tag);
  assign write_through = wr_en && tag_valid && (wr_addr == tag);

  // While a fill is in flight the RAM output is the freshest copy of the word
  assign rdata = fill ? ram_rdata : cache_data;

  // Tag and fill flag: a served miss retargets the cache and schedules a fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag       <= {SCREEN_AW{1'b0}};
      tag_valid <= 1'b0;
      fill      <= 1'b0;
    end else begin
      fill <= fill_start;
      if (fill_start) begin
        tag       <= lookup_addr;
        tag_valid <= 1'b1;
      end
    end
  end

  // Data word: a CPU write-through beats a fill landing on the same edge,
  // because the RAM output still carries the pre-write value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_data <= {SCREEN_DW{1'b0}};
    end else if (write_through) begin
      cache_data <= wr_data;
    end else if (fill) begin
      cache_data <= ram_rdata;
    end
  end

endmodule

// File: rtl/screen_ram_arbiter.sv
// Arbiter sharing one single-port screen RAM between the VGA scanner and the CPU.
// VGA misses normally own the RAM; the CPU gets it otherwise, and is forced
// through after MAX_WAIT consecutive stalled cycles (the VGA then gets the
// cached word and vga_stale pulses).
// Ports:
//   clk : sole clock, rising edge
//   rst : asynchronous active-high reset; all outputs are 0 while asserted
//   bus : screen_ram_arbiter_if.slave carrying the VGA, CPU and RAM sides
module screen_ram_arbiter
  import hack_screen_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 32'd32
) (
  input  logic                 clk,
  input  logic                 rst,
  screen_ram_arbiter_if.slave  bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_STEP  = WAIT_W'(1);

  logic              vga_hit;
  logic              vga_conflict;
  logic              forced;
  logic              vga_miss;
  logic              cpu_grant;
  logic              cpu_wr_grant;
  logic              stale_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              rd_valid;
  logic              stale;
  screen_addr_t      ram_addr;
  logic              ram_we;
  screen_word_t      ram_wdata;
  screen_word_t      cache_rdata;

  screen_word_cache u_cache (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (bus.vga_addr),
    .hit         (vga_hit),
    .fill_start  (vga_miss),
    .ram_rdata   (bus.ram_rdata),
    .wr_en       (cpu_wr_grant),
    .wr_addr     (bus.cpu_addr),
    .wr_data     (bus.cpu_wdata),
    .rdata       (cache_rdata)
  );

  // Arbitration: a VGA miss owns the RAM unless the CPU has waited long enough
  always_comb begin
    vga_conflict = bus.vga_en && !vga_hit;
    forced       = bus.cpu_req && (wait_cnt == WAIT_LIMIT);
    // Gating with rst keeps every output at 0 while reset is held
    vga_miss     = vga_conflict && !forced && !rst;
    cpu_grant    = bus.cpu_req && !vga_miss && !rst;
    cpu_wr_grant = cpu_grant && bus.cpu_we;
    stale_next   = vga_conflict && forced && !rst;
  end

  // RAM port mux: VGA miss, else granted CPU, else idle at address 0
  always_comb begin
    ram_addr  = {SCREEN_AW{1'b0}};
    ram_we    = 1'b0;
    ram_wdata = {SCREEN_DW{1'b0}};
    if (vga_miss) begin
      ram_addr = bus.vga_addr;
    end else if (cpu_grant) begin
      ram_addr  = bus.cpu_addr;
      ram_we    = bus.cpu_we;
      ram_wdata = bus.cpu_wdata;
    end else begin
      ram_addr  = {SCREEN_AW{1'b0}};
      ram_we    = 1'b0;
      ram_wdata = {SCREEN_DW{1'b0}};
    end
  end

  // Wait counter next value: counts stalled request cycles, saturating
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!bus.cpu_req || cpu_grant) begin
      wait_cnt_next = {WAIT_W{1'b0}};
    end else if (wait_cnt < WAIT_LIMIT) begin
      wait_cnt_next = wait_cnt + WAIT_STEP;
    end else begin
      wait_cnt_next = wait_cnt;
    end
  end

  // Sequential state: wait counter, read-valid and stale pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= {WAIT_W{1'b0}};
      rd_valid <= 1'b0;
      stale    <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      rd_valid <= cpu_grant && !bus.cpu_we;
      stale    <= stale_next;
    end
  end

  assign bus.ram_addr   = ram_addr;
  assign bus.ram_we     = ram_we;
  assign bus.ram_wdata  = ram_wdata;
  assign bus.cpu_ready  = cpu_grant;
  assign bus.cpu_rvalid = rd_valid;
  assign bus.cpu_rdata  = rd_valid ? bus.ram_rdata : {SCREEN_DW{1'b0}};
  assign bus.vga_rdata  = cache_rdata;
  assign bus.vga_stale  = stale;

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// Self-checking bench for screen_ram_arbiter (MAX_WAIT = 4).
// A reference model views the screen as a plain memory: the VGA side always
// returns the current memory content of the last address it fetched, the CPU
// read returns memory content, and arbitration follows the ownership rules.
module tb_screen_ram_arbiter;
  import hack_screen_pkg::*;

  localparam int MW    = 4;
  localparam int DEPTH = 8192;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  screen_ram_arbiter_if bus ();

  screen_ram_arbiter #(.MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: synchronous, one-cycle read latency
  screen_word_t ram [0:DEPTH-1];
  always @(posedge clk) begin
    bus.ram_rdata <= ram[bus.ram_addr];
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
  end

  function automatic screen_word_t init_word(input int i);
    return 16'(i) ^ 16'h5A00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  screen_word_t ref_mem [0:DEPTH-1];
  logic         m_valid;
  screen_addr_t m_tag;
  int           m_wait;
  screen_word_t exp_vga;
  logic         exp_stale;
  logic         exp_rvalid;
  screen_word_t exp_rdata;
  logic         m_hit, vga_wants, m_forced, vga_gets, cpu_gets;
  screen_addr_t exp_addr;

  // Compare process: check every cycle at the falling edge, then advance the model
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_valid = 1'b0; m_tag = '0; m_wait = 0;
    exp_vga = '0; exp_stale = 1'b0; exp_rvalid = 1'b0; exp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst vga_rdata", bus.vga_rdata, 32'd0);
        check("rst vga_stale", bus.vga_stale, 32'd0);
        check("rst cpu_ready", bus.cpu_ready, 32'd0);
        check("rst cpu_rvalid", bus.cpu_rvalid, 32'd0);
        check("rst cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst ram_addr", bus.ram_addr, 32'd0);
        check("rst ram_we", bus.ram_we, 32'd0);
        check("rst ram_wdata", bus.ram_wdata, 32'd0);
        m_valid = 1'b0; m_tag = '0; m_wait = 0;
        exp_vga = '0; exp_stale = 1'b0; exp_rvalid = 1'b0; exp_rdata = '0;
      end else begin
        check("model vga_rdata", bus.vga_rdata, exp_vga);
        check("model vga_stale", bus.vga_stale, exp_stale);
        check("model cpu_rvalid", bus.cpu_rvalid, exp_rvalid);
        if (exp_rvalid) check("model cpu_rdata", bus.cpu_rdata, exp_rdata);

        m_hit     = m_valid && (bus.vga_addr == m_tag);
        vga_wants = bus.vga_en && !m_hit;
        m_forced  = bus.cpu_req && (m_wait == MW);
        vga_gets  = vga_wants && !m_forced;
        cpu_gets  = bus.cpu_req && !vga_gets;
        exp_addr  = vga_gets ? bus.vga_addr : (cpu_gets ? bus.cpu_addr : 13'h0000);

        check("model cpu_ready", bus.cpu_ready, cpu_gets);
        check("model ram_addr", bus.ram_addr, exp_addr);
        check("model ram_we", bus.ram_we, cpu_gets && bus.cpu_we);
        check("model ram_wdata", bus.ram_wdata, cpu_gets ? bus.cpu_wdata : 16'h0000);

        exp_rvalid = cpu_gets && !bus.cpu_we;
        exp_rdata  = ref_mem[bus.cpu_addr];
        if (cpu_gets && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
        if (vga_gets) begin
          m_valid = 1'b1;
          m_tag   = bus.vga_addr;
        end
        exp_vga   = m_valid ? ref_mem[m_tag] : 16'h0000;
        exp_stale = vga_wants && m_forced;
        if (!bus.cpu_req || cpu_gets) m_wait = 0;
        else if (m_wait < MW) m_wait = m_wait + 1;
      end
    end
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    rst = 1'b1;
    bus.vga_en = 1'b1; bus.vga_addr = 13'h0123;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0AAA; bus.cpu_wdata = 16'hFFFF;
    repeat (3) cyc();
    check("hand reset cpu_ready", bus.cpu_ready, 32'd0);
    check("hand reset ram_addr", bus.ram_addr, 32'd0);
    check("hand reset ram_we", bus.ram_we, 32'd0);
    check("hand reset vga_rdata", bus.vga_rdata, 32'd0);

    // VGA 5,5,5,6: RAM reads on cycles 0 and 3 only
    rst = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_wdata = 16'h0000;
    bus.vga_addr = 13'd5; #1;
    check("hand seq c0 ram_addr", bus.ram_addr, 32'd5);
    cyc(); #1;
    check("hand seq c1 vga_rdata", bus.vga_rdata, 32'h5A05);
    check("hand seq c1 ram_addr", bus.ram_addr, 32'd0);
    cyc(); #1;
    check("hand seq c2 vga_rdata", bus.vga_rdata, 32'h5A05);
    check("hand seq c2 ram_addr", bus.ram_addr, 32'd0);
    cyc();
    check("hand seq c3 vga_rdata", bus.vga_rdata, 32'h5A05);
    bus.vga_addr = 13'd6; #1;
    check("hand seq c3 ram_addr", bus.ram_addr, 32'd6);
    cyc();
    check("hand seq c4 vga_rdata", bus.vga_rdata, 32'h5A06);

    // CPU write 0xBEEF to 5 while VGA hits 5
    bus.vga_addr = 13'd5;
    cyc();
    cyc();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'd5; bus.cpu_wdata = 16'hBEEF; #1;
    check("hand wt cpu_ready", bus.cpu_ready, 32'd1);
    check("hand wt ram_we", bus.ram_we, 32'd1);
    check("hand wt ram_addr", bus.ram_addr, 32'd5);
    cyc();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; #1;
    check("hand wt vga_rdata", bus.vga_rdata, 32'hBEEF);
    check("hand wt ram word", ram[5], 32'hBEEF);

    // CPU read of the top address with VGA idle
    bus.vga_en = 1'b0; bus.cpu_req = 1'b1; bus.cpu_addr = 13'h1FFF; #1;
    check("hand rd ram_addr", bus.ram_addr, 32'h1FFF);
    check("hand rd cpu_ready", bus.cpu_ready, 32'd1);
    cyc();
    bus.cpu_req = 1'b0; #1;
    check("hand rd cpu_rvalid", bus.cpu_rvalid, 32'd1);
    check("hand rd cpu_rdata", bus.cpu_rdata, 32'h45FF);
    check("hand rd vga idle hold", bus.vga_rdata, 32'hBEEF);
    cyc();
    check("hand rd rvalid drop", bus.cpu_rvalid, 32'd0);

    // Fill of 7 and CPU write of 7 on the same edge
    bus.vga_en = 1'b1; bus.vga_addr = 13'd7; #1;
    check("hand race ram_addr", bus.ram_addr, 32'd7);
    cyc();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'd7; bus.cpu_wdata = 16'h1234; #1;
    check("hand race cpu_ready", bus.cpu_ready, 32'd1);
    check("hand race fill data", bus.vga_rdata, 32'h5A07);
    cyc();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; #1;
    check("hand race vga_rdata", bus.vga_rdata, 32'h1234);

    // Starvation: VGA misses every cycle, CPU forced on the 5th
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0100;
    for (int i = 0; i < 5; i++) begin
      bus.vga_addr = 13'h0200 + 13'(i); #1;
      check("hand starve cpu_ready", bus.cpu_ready, 32'(i == 4));
      cyc();
    end
    bus.cpu_req = 1'b0; bus.vga_en = 1'b0; #1;
    check("hand starve vga_stale", bus.vga_stale, 32'd1);
    check("hand starve cpu_rvalid", bus.cpu_rvalid, 32'd1);
    check("hand starve cpu_rdata", bus.cpu_rdata, 32'h5B00);
    check("hand starve vga_rdata", bus.vga_rdata, 32'h5803);
    cyc();
    check("hand starve stale drop", bus.vga_stale, 32'd0);
    bus.cpu_req = 1'b1; bus.vga_en = 1'b1; bus.vga_addr = 13'h0300; #1;
    check("hand starve count cleared", bus.cpu_ready, 32'd0);
    cyc();
    bus.cpu_req = 1'b0; bus.vga_en = 1'b0;
    cyc();

    // Reset in the middle of a granted CPU read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0042; #1;
    check("hand cut cpu_ready pre", bus.cpu_ready, 32'd1);
    rst = 1'b1; #1;
    check("hand cut cpu_ready", bus.cpu_ready, 32'd0);
    check("hand cut ram_addr", bus.ram_addr, 32'd0);
    check("hand cut vga_rdata", bus.vga_rdata, 32'd0);
    check("hand cut cpu_rvalid", bus.cpu_rvalid, 32'd0);
    cyc();
    cyc();
    bus.cpu_req = 1'b0; rst = 1'b0;
    cyc();
    check("hand cut no rvalid", bus.cpu_rvalid, 32'd0);
    bus.vga_en = 1'b1; bus.vga_addr = 13'h0203; #1;
    check("hand cut first miss", bus.ram_addr, 32'h0203);
    cyc();
    check("hand cut refill data", bus.vga_rdata, 32'h5803);
    bus.vga_en = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
